// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: scans the voice table for each note event and writes one slot.
// Optional voice stealing when all voices are busy: define MIDI_VOICE_STEAL_EN.
module midi_voice_alloc #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                  EXT_CLK,
    input  logic                  RST,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic                  ev_off,
    input  logic [6:0]            ev_note,
    input  logic [6:0]            ev_vel,
    input  logic [3:0]            ev_chan,
    input  logic                  all_off,
    output logic [NUM_VOICES-1:0] voice_en,
    output logic                  voice_wr,
    output logic [IDX_W-1:0]      voice_idx,
    output logic [6:0]            voice_note,
    output logic [6:0]            voice_vel,
    output logic [3:0]            voice_chan,
    output logic                  steal,
    output logic                  drop
);

    typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;
    typedef enum logic [1:0] {EvOn, EvOff, EvBad} kind_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VOICES - 1);

    state_e           state;
    kind_e            ev_kind;
    logic [6:0]       ev_note_l;
    logic [6:0]       ev_vel_l;
    logic [3:0]       ev_chan_l;
    logic [IDX_W-1:0] scan_cnt;
    logic [6:0]       tab_note [NUM_VOICES];
    logic [3:0]       tab_chan [NUM_VOICES];
    logic             match_found, free_found;
    logic [IDX_W-1:0] match_idx, free_idx;
    logic             scan_hit;
    logic             do_write;
    logic [IDX_W-1:0] tgt_idx;

    assign ev_ready = (state == StIdle);
    assign scan_hit = voice_en[scan_cnt] && (tab_note[scan_cnt] == ev_note_l) &&
                      (tab_chan[scan_cnt] == ev_chan_l);

`ifdef MIDI_VOICE_STEAL_EN
    logic [AGE_W-1:0] age [NUM_VOICES];
    logic             old_found;
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;
    logic             tgt_steal;
`endif

    always_comb begin
        do_write = 1'b0;
        tgt_idx  = '0;
`ifdef MIDI_VOICE_STEAL_EN
        tgt_steal = 1'b0;
`endif
        case (ev_kind)
            EvOn: begin
                if (match_found) begin
                    do_write = 1'b1;
                    tgt_idx  = match_idx;
                end else if (free_found) begin
                    do_write = 1'b1;
                    tgt_idx  = free_idx;
                end
`ifdef MIDI_VOICE_STEAL_EN
                else begin
                    do_write  = 1'b1;
                    tgt_idx   = old_idx;
                    tgt_steal = 1'b1;
                end
`endif
            end
            EvOff: begin
                do_write = match_found;
                tgt_idx  = match_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge EXT_CLK) begin
        if (RST) begin
            state       <= StIdle;
            ev_kind     <= EvBad;
            ev_note_l   <= '0;
            ev_vel_l    <= '0;
            ev_chan_l   <= '0;
            scan_cnt    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            voice_en    <= '0;
            voice_wr    <= 1'b0;
            voice_idx   <= '0;
            voice_note  <= '0;
            voice_vel   <= '0;
            voice_chan  <= '0;
            drop        <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                tab_note[i] <= '0;
                tab_chan[i] <= '0;
            end
        end else if (all_off) begin
            // Panic aborts any in-flight event silently.
            state    <= StIdle;
            voice_en <= '0;
            voice_wr <= 1'b0;
            drop     <= 1'b0;
        end else begin
            voice_wr <= 1'b0;
            drop     <= 1'b0;
            case (state)
                StIdle: begin
                    if (ev_valid) begin
                        if (ev_on && !ev_off && ev_vel != 7'd0) ev_kind <= EvOn;
                        else if (ev_on != ev_off)               ev_kind <= EvOff;
                        else                                    ev_kind <= EvBad;
                        ev_note_l   <= ev_note;
                        ev_vel_l    <= ev_vel;
                        ev_chan_l   <= ev_chan;
                        scan_cnt    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        state       <= StScan;
                    end
                end
                StScan: begin
                    if (scan_hit && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_cnt;
                    end
                    if (!voice_en[scan_cnt] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_cnt;
                    end
                    if (scan_cnt == LastIdx) state <= StCommit;
                    scan_cnt <= scan_cnt + 1'b1;
                end
                StCommit: begin
                    state <= StIdle;
                    if (do_write) begin
                        voice_wr   <= 1'b1;
                        voice_idx  <= tgt_idx;
                        voice_note <= ev_note_l;
                        voice_chan <= ev_chan_l;
                        if (ev_kind == EvOn) begin
                            voice_vel         <= ev_vel_l;
                            voice_en[tgt_idx] <= 1'b1;
                            tab_note[tgt_idx] <= ev_note_l;
                            tab_chan[tgt_idx] <= ev_chan_l;
                        end else begin
                            voice_vel         <= 7'd0;
                            voice_en[tgt_idx] <= 1'b0;
                        end
                    end else begin
                        drop <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef MIDI_VOICE_STEAL_EN
    always_ff @(posedge EXT_CLK) begin
        steal <= !RST && !all_off && (state == StCommit) && do_write && tgt_steal;
    end

    // Oldest = max age among active voices; strict compare keeps the lowest index on ties.
    always_ff @(posedge EXT_CLK) begin
        if (RST || all_off) begin
            old_found <= 1'b0;
            old_idx   <= '0;
            old_age   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
        end else if (state == StIdle && ev_valid) begin
            old_found <= 1'b0;
            old_idx   <= '0;
            old_age   <= '0;
        end else if (state == StScan) begin
            if (voice_en[scan_cnt] && (!old_found || age[scan_cnt] > old_age)) begin
                old_found <= 1'b1;
                old_idx   <= scan_cnt;
                old_age   <= age[scan_cnt];
            end
        end else if (state == StCommit && do_write && ev_kind == EvOn) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == tgt_idx) age[i] <= '0;
                else if (voice_en[i] && age[i] != {AGE_W{1'b1}}) age[i] <= age[i] + 1'b1;
            end
        end
    end
`else
    assign steal = 1'b0;
`endif

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: a behavioural allocator model predicts every write/drop.
module tb_midi_voice_alloc;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ev_valid, ev_on, ev_off, all_off;
    logic [6:0] ev_note, ev_vel;
    logic [3:0] ev_chan;
    logic       ev_ready;
    logic [7:0] voice_en;
    logic       voice_wr, steal, drop;
    logic [2:0] voice_idx;
    logic [6:0] voice_note, voice_vel;
    logic [3:0] voice_chan;

    midi_voice_alloc dut (
        .EXT_CLK    (clk),
        .RST        (rst),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_off     (ev_off),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .ev_chan    (ev_chan),
        .all_off    (all_off),
        .voice_en   (voice_en),
        .voice_wr   (voice_wr),
        .voice_idx  (voice_idx),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .voice_chan (voice_chan),
        .steal      (steal),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       drop;
        logic       steal;
        logic [2:0] idx;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0] chan;
        logic [7:0] en;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;

    logic       m_act  [N];
    logic [6:0] m_note [N];
    logic [3:0] m_chan [N];
    int         m_age  [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] model_en();
        logic [7:0] en;
        for (int i = 0; i < N; i++) en[i] = m_act[i];
        return en;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 1'b0;
            m_age[i] = 0;
        end
    endtask

    task automatic model_event(input logic on, input logic off, input logic [6:0] n,
                               input logic [6:0] v, input logic [3:0] c, output exp_t e);
        int  hit = -1, fr = -1, old = -1, tgt = -1;
        logic is_on, is_off, stl;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && m_note[i] == n && m_chan[i] == c && hit < 0) hit = i;
            if (!m_act[i] && fr < 0) fr = i;
            if (m_act[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        is_on  = on && !off && (v != 0);
        is_off = (off && !on) || (on && !off && v == 0);
        stl    = 1'b0;
        e      = '0;
        e.drop = 1'b1;
        if (is_on) begin
            if (hit >= 0) tgt = hit;
            else if (fr >= 0) tgt = fr;
`ifdef MIDI_VOICE_STEAL_EN
            else begin
                tgt = old;
                stl = 1'b1;
            end
`endif
            if (tgt >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (i == tgt) m_age[i] = 0;
                    else if (m_act[i] && m_age[i] < 255) m_age[i]++;
                end
                m_act[tgt]  = 1'b1;
                m_note[tgt] = n;
                m_chan[tgt] = c;
                e.drop  = 1'b0;
                e.steal = stl;
                e.idx   = 3'(tgt);
                e.note  = n;
                e.vel   = v;
                e.chan  = c;
            end
        end else if (is_off && hit >= 0) begin
            m_act[hit] = 1'b0;
            e.drop = 1'b0;
            e.idx  = 3'(hit);
            e.note = n;
            e.vel  = 7'd0;
            e.chan = c;
        end
        e.en = model_en();
    endtask

    // Scoreboard consumer: every write or drop pops one prediction.
    always @(negedge clk) begin
        if (!rst && (voice_wr || drop)) begin
            exp_t e;
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_output", {voice_wr, drop}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("drop", drop, e.drop);
                check("voice_wr", voice_wr, !e.drop);
                check("steal", steal, e.steal);
                check("voice_en", voice_en, e.en);
                if (!e.drop) begin
                    check("voice_idx", voice_idx, e.idx);
                    check("voice_note", voice_note, e.note);
                    check("voice_vel", voice_vel, e.vel);
                    check("voice_chan", voice_chan, e.chan);
                end
            end
        end
    end

    task automatic send(input logic on, input logic off, input logic [6:0] n,
                        input logic [6:0] v, input logic [3:0] c);
        exp_t e;
        int   start, cyc;
        model_event(on, off, n, v, c, e);
        sb.push_back(e);
        start = n_out;
        @(negedge clk);
        check("ready_before", ev_ready, 1'b1);
        ev_valid = 1'b1; ev_on = on; ev_off = off; ev_note = n; ev_vel = v; ev_chan = c;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        cyc = 0;
        while (!(voice_wr || drop) && cyc < 30) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (cyc >= 30) begin
            check("timeout", 32'd0, 32'd1);
            void'(sb.pop_back());
        end else begin
            check("latency", cyc, N + 1);
            check("ready_with_wr", ev_ready, 1'b1);
        end
        @(negedge clk);
        #1 check("one_output", n_out - start, 32'd1);
    endtask

    task automatic panic();
        @(negedge clk);
        all_off = 1'b1;
        @(posedge clk);
        #1 all_off = 1'b0;
        model_clear();
        check("panic_en", voice_en, 8'h00);
    endtask

    initial begin
        int start;
        rst = 1'b1; all_off = 1'b0;
        ev_valid = 1'b1; ev_on = 1'b1; ev_off = 1'b0;
        ev_note = 7'd60; ev_vel = 7'd100; ev_chan = 4'd0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        rst = 1'b0;
        check("rst_en", voice_en, 8'h00);
        check("rst_wr", voice_wr, 1'b0);
        check("rst_idx", voice_idx, 3'd0);
        check("rst_note", voice_note, 7'd0);
        check("rst_vel", voice_vel, 7'd0);
        check("rst_chan", voice_chan, 4'd0);
        check("rst_steal", steal, 1'b0);
        check("rst_drop", drop, 1'b0);
        check("rst_ready", ev_ready, 1'b1);
        repeat (N + 4) @(negedge clk);
        check("rst_event_ignored", n_out, 32'd0);

        send(1, 0, 60, 100, 0);
        panic();
        send(1, 0, 60, 100, 0);
        send(1, 0, 62, 100, 0);
        send(1, 0, 64, 100, 0);
        send(0, 1, 62, 0, 0);
        panic();
        send(1, 0, 60, 100, 0);
        send(1, 0, 60, 50, 0);
        panic();
        for (int i = 0; i < 8; i++) send(1, 0, 7'(60 + i), 7'(90 + i), 0);
        send(1, 0, 70, 80, 0);
        send(1, 0, 71, 80, 0);
        panic();
        send(1, 0, 61, 0, 0);
        send(0, 1, 99, 0, 0);
        send(1, 1, 40, 60, 1);
        send(0, 0, 40, 60, 1);
        send(1, 0, 40, 60, 1);
        send(0, 1, 40, 0, 2);

        // Panic mid-scan with a fresh event offered alongside it.
        start = n_out;
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_off = 1'b0; ev_note = 7'd50; ev_vel = 7'd70;
        ev_chan = 4'd3;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b1; ev_note = 7'd51; all_off = 1'b1;
        @(posedge clk);
        #1 all_off = 1'b0; ev_valid = 1'b0;
        model_clear();
        check("abort_en", voice_en, 8'h00);
        check("abort_ready", ev_ready, 1'b1);
        repeat (N + 6) @(negedge clk);
        check("abort_no_out", n_out - start, 32'd0);

        for (int k = 0; k < 40; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            send(r <= 5 || r == 9, r >= 6, 7'(60 + $urandom_range(0, 11)),
                 ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                 4'($urandom_range(0, 1)));
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
